// File: rtl/pipe_skid_r0_pkg.sv
// rtl/pipe_skid_r0_pkg.sv - state encoding and helpers shared by the skid stage
package pipe_skid_r0_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Number of held entries, decoded from the registered state only
    function automatic logic [1:0] occupancy_of(state_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_r0_if.sv
// rtl/pipe_skid_r0_if.sv - valid/ready handshake bundle for the skid stage
interface pipe_skid_r0_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    // Stage side: receives from the producer, presents to the consumer
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Environment side: producer and consumer combined
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pipe_skid_r0_sat_counter.sv
// rtl/pipe_skid_r0_sat_counter.sv - saturating event counter, reset-only clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count events, sticking at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_r0.sv
// rtl/pipe_skid_r0.sv - registered valid/ready stage with two-entry skid buffer
module pipe_skid_r0
    import pipe_skid_r0_pkg::*;
#(
    parameter int BIT_WIDTH   = 4,
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    pipe_skid_r0_if.slave          bus,
    output logic                   en_n,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int W = BIT_WIDTH * DEPTH;

    state_t         state;
    logic [W-1:0]   main_q;
    logic [W-1:0]   skid_q;
    logic           push;
    logic           pop;

    // All handshake outputs come from registered state, so no input reaches them combinationally
    assign bus.in_ready  = (state != ST_FULL);
    assign bus.out_valid = (state != ST_EMPTY);
    assign bus.out_data  = main_q;
    assign occupancy     = occupancy_of(state);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Downstream delay stage advances only on an accepted transfer
    assign en_n = ~pop;

    // Occupancy FSM with main/skid data movement; flush overrides any push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state  <= ST_ONE;
                        main_q <= bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_q <= bus.in_data;
                    end else if (push) begin
                        state  <= ST_FULL;
                        skid_q <= bus.in_data;
                    end else if (pop) begin
                        state  <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state  <= ST_ONE;
                        main_q <= skid_q;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.out_valid & ~bus.out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_r0.sv
// tb/tb_pipe_skid_r0.sv - directed vector and scoreboard bench for pipe_skid_r0
module tb_pipe_skid_r0;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       en_n;
    logic [1:0] occupancy;
    logic [3:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_r0_if #(.W(8)) bus ();

    pipe_skid_r0 #(
        .BIT_WIDTH   (4),
        .DEPTH       (2),
        .STALL_CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .en_n      (en_n),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic [1:0] occ;
        logic       ov;
        logic       ir;
        logic [7:0] od;
        logic       en;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic       ir0;
    logic       ov0;

    initial begin
        // Streaming
        vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 2'd1, 1'b1, 1'b1, 8'h11, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b1, 2'd1, 1'b1, 1'b1, 8'h22, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 2'd1, 1'b1, 1'b1, 8'h33, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 8'h33, 1'b1};
        // Skid fill and drain
        vecs[4]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hA1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'hB2, 1'b0, 2'd2, 1'b1, 1'b0, 8'hA1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 2'd2, 1'b1, 1'b0, 8'hA1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 2'd1, 1'b1, 1'b1, 8'hB2, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 8'hB2, 1'b1};
        // Flush beats a simultaneous push
        vecs[9]  = '{1'b0, 1'b1, 8'h44, 1'b0, 2'd1, 1'b1, 1'b1, 8'h44, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'h55, 1'b0, 2'd2, 1'b1, 1'b0, 8'h44, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'hCC, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 1'b1};
        // Flush with a simultaneous pop
        vecs[13] = '{1'b0, 1'b1, 8'h66, 1'b1, 2'd1, 1'b1, 1'b1, 8'h66, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #12;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ov", 32'(bus.out_valid), 32'd1 - 32'd1);
        chk("rst_ir", 32'(bus.in_ready), 32'd1);
        chk("rst_od", 32'(bus.out_data), 32'h00);
        chk("rst_en_n", 32'(en_n), 32'd1);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            step();
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vecs[i].occ));
            chk($sformatf("v%0d_ov", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d_ir", i), 32'(bus.in_ready), 32'(vecs[i].ir));
            chk($sformatf("v%0d_od", i), 32'(bus.out_data), 32'(vecs[i].od));
            chk($sformatf("v%0d_en_n", i), 32'(en_n), 32'(vecs[i].en));
        end
        // Stall edges in the table: vectors 5, 6, 10, 11
        chk("table_stall", 32'(stall_cnt), 32'd4);

        // Stall counter saturation, then flush must not clear it
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("stall_sat", 32'(stall_cnt), 32'hF);
        chk("stall_hold_od", 32'(bus.out_data), 32'h77);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk("stall_after_flush", 32'(stall_cnt), 32'hF);
        chk("flush_occ", 32'(occupancy), 32'd0);

        // Asynchronous reset while full
        drive(1'b0, 1'b1, 8'h81, 1'b0);
        step();
        drive(1'b0, 1'b1, 8'h92, 1'b0);
        step();
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_ov", 32'(bus.out_valid), 32'd0);
        chk("arst_ir", 32'(bus.in_ready), 32'd1);
        chk("arst_od", 32'(bus.out_data), 32'h00);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        chk("arst_en_n", 32'(en_n), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random valid/ready against a FIFO scoreboard
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            #3;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_pop_empty", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_d = q.pop_front();
                    chk("rand_data", 32'(bus.out_data), 32'(exp_d));
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
            ir0 = bus.in_ready;
            ov0 = bus.out_valid;
            bus.out_ready = ~bus.out_ready;
            bus.in_valid  = ~bus.in_valid;
            #1;
            chk("rand_ir_comb", 32'(bus.in_ready), 32'(ir0));
            chk("rand_ov_comb", 32'(bus.out_valid), 32'(ov0));
            bus.out_ready = ~bus.out_ready;
            bus.in_valid  = ~bus.in_valid;
        end
        step();
        chk("rand_final_occ", 32'(occupancy), 32'(q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
